stereo_disparity_engine: RTL and testbench
==========================================

// Module: stereo_disparity_engine
// PURPOSE
// Parametrised block-matching disparity engine; successor to the fixed 6x6 / 320x240 stereo matcher.
// Per frame: slides a BLOCK x BLOCK window over the left image and searches disparities 0..min(MAX_DISP-1,x).
// Runtime-selectable SAD or SSD cost; writes the best disparity per left position to a result RAM.
// Costs above a threshold produce an INVALID code. Sits between the left/right frame BRAMs and the depth/display path.
// PARAMETERS
// IMG_W     320  image width in pixels
// IMG_H     240  image height in pixels
// BLOCK     6    square window size, >=2
// MAX_DISP  64   disparity candidates searched, <=2**DISP_W-1
// PIX_W     8    bits per pixel
// DISP_W    8    result width; all-ones = INVALID
// RD_LAT    2    read latency of left/right BRAMs in cycles
// PORTS
// clk_100mhz   in   1       system clock
// sys_rst_n    in   1       asynchronous active-low reset
// start        in   1       one-cycle pulse, begin frame; ignored while busy
// metric_sel   in   1       0=SAD, 1=SSD; sampled on accepted start
// cost_thresh  in   COST_W  max accepted best cost; sampled on accepted start
// busy         out  1       high from accepted start until done
// done         out  1       one-cycle pulse after last result write
// left_addr    out  ADDR_W  left BRAM address, y*IMG_W+x (ADDR_W=clog2(IMG_W*IMG_H))
// right_addr   out  ADDR_W  right BRAM address, same mapping
// left_pix     in   PIX_W   left BRAM data, RD_LAT after address
// right_pix    in   PIX_W   right BRAM data, RD_LAT after address
// res_we       out  1       result write strobe, one cycle per position
// res_addr     out  ADDR_W  result address, y*IMG_W+x (window top-left)
// res_din      out  DISP_W  best disparity or INVALID
// BEHAVIOUR
// - Reset (async, any time): all outputs 0, FSM to IDLE, counters cleared; no partial write; next start begins a clean frame.
// - Positions: y=0..IMG_H-BLOCK outer loop, x=0..IMG_W-BLOCK inner loop, raster order.
// - Candidate d: cost = sum over i,j<BLOCK of f(L(x+i,y+j) - R(x-d+i,y+j)); f=|.| (SAD) or (.)^2 (SSD).
// - d runs 0..min(MAX_DISP-1,x), ascending; right reads never go below x=0.
// - COST_W = clog2(BLOCK*BLOCK*(2**PIX_W-1)**2+1); arithmetic unsigned, no saturation needed.
// - Difference is signed PIX_W+1 bits; SAD takes magnitude; SSD uses a full 2*PIX_W square.
// - Best update: strict cost<best, so ties keep the smaller disparity; best resets to all-ones per position.
// - Result: res_din = best_d if best_cost <= cost_thresh, else {DISP_W{1'b1}}.
// - FSM:
//   IDLE    -> ISSUE on start; busy<=1.
//   ISSUE   one left+right address pair per cycle, BLOCK*BLOCK cycles (j outer, i inner) -> DRAIN.
//   DRAIN   wait until the RD_LAT+2 valid shift register empties (accumulator final) -> COMPARE.
//   COMPARE update best -> ISSUE (next d) or WRITE (last d).
//   WRITE   res_we=1 for one cycle -> ISSUE (next x/y) or FIN (last position).
//   FIN     done=1 for one cycle, busy<=0 -> IDLE.
// - Read data is tagged by a valid shift register of depth RD_LAT; the accumulator clears on the first tagged sample of a candidate.
// - Per-candidate cycles: BLOCK^2 + RD_LAT + 4. start while busy is dropped (no queueing).
// - res_addr/res_din are stable during res_we; res_we never asserts outside WRITE.
// STRUCTURE
// - stereo_pkg: metric_e {METRIC_SAD, METRIC_SSD}; disp_state_e; function cost_width(BLOCK,PIX_W).
// - Sub-module block_cost_accum: valid/clear/metric in -> pipelined diff, abs/square, accumulate -> cost, cost_valid.
// - Top level holds the FSM, x/y/d/i/j counters, address generation, best tracking and result port.
// TESTING (cfg IMG_W=16 IMG_H=8 BLOCK=2 MAX_DISP=4 RD_LAT=2, BRAM models with matching latency)
// - Identical random images, SAD, thresh max -> 105 writes (15x7), all res_din=0, done once, busy low after.
// - R(x)=L(x+2), distinct texture -> res_din=2 for x>=2; x=0 gives 0, x=1 gives 1 (search limited).
// - Uniform L=10, R=13, thresh=20: SAD cost 12 -> res_din=0; SSD cost 36 -> res_din=8'hFF.
// - Random images, thresh=0 -> every position with nonzero min cost writes 8'hFF; scoreboard vs ref model.
// - sys_rst_n low mid-ISSUE -> same-cycle busy=0, res_we=0; restart gives a full 105-write frame.
// - start pulsed every 50 cycles during a frame -> ignored; exactly 105 writes and one done.

Source files
------------

// File: rtl/stereo_disparity_engine_pkg.sv
// Shared types and helpers for the stereo block-matching disparity engine.
package stereo_pkg;

    // Matching cost function applied to each pixel difference.
    typedef enum logic {
        METRIC_SAD = 1'b0,
        METRIC_SSD = 1'b1
    } metric_e;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_FIN     = 3'd5
    } disp_state_e;

    // Bits needed to hold the worst-case SSD of one window without overflow.
    function automatic int cost_width(input int block, input int pix_w);
        longint pix_max;
        longint max_cost;
        pix_max  = (longint'(1) << pix_w) - longint'(1);
        max_cost = longint'(block) * longint'(block) * pix_max * pix_max + longint'(1);
        return $clog2(max_cost);
    endfunction

endpackage

// File: rtl/stereo_disparity_engine_accum.sv
// Per-candidate cost pipeline: difference, |d| or d^2, then accumulate.
module block_cost_accum
    import stereo_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COST_W = 22
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              clear_i,
    input  metric_e           metric_i,
    input  logic [PIX_W-1:0]  l_pix_i,
    input  logic [PIX_W-1:0]  r_pix_i,
    output logic [COST_W-1:0] cost_o,
    output logic              busy_o
);

    logic                    v1_q;
    logic                    clr1_q;
    logic signed [PIX_W:0]   diff_q;
    logic                    v2_q;
    logic                    clr2_q;
    logic [2*PIX_W-1:0]      term_q;
    logic [2*PIX_W-1:0]      term_d;
    logic [PIX_W-1:0]        mag;
    logic [COST_W-1:0]       acc_q;

    // Magnitude of the signed difference, then either pass it or square it.
    always_comb begin
        mag    = diff_q[PIX_W] ? PIX_W'(-diff_q) : PIX_W'(diff_q);
        term_d = (2*PIX_W)'(mag);
        if (metric_i == METRIC_SSD) begin
            term_d = (2*PIX_W)'(mag) * (2*PIX_W)'(mag);
        end
    end

    // Three-stage pipeline; the first tagged sample of a candidate restarts the sum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            clr1_q <= 1'b0;
            diff_q <= '0;
            v2_q   <= 1'b0;
            clr2_q <= 1'b0;
            term_q <= '0;
            acc_q  <= '0;
        end else begin
            v1_q   <= valid_i;
            clr1_q <= clear_i;
            diff_q <= $signed({1'b0, l_pix_i}) - $signed({1'b0, r_pix_i});
            v2_q   <= v1_q;
            clr2_q <= clr1_q;
            term_q <= term_d;
            if (v2_q) begin
                acc_q <= clr2_q ? COST_W'(term_q) : acc_q + COST_W'(term_q);
            end
        end
    end

    assign cost_o = acc_q;
    assign busy_o = v1_q | v2_q;

endmodule

// File: rtl/stereo_disparity_engine.sv
// Block-matching disparity engine: sequencer, address generation, best tracking.
module stereo_disparity_engine
    import stereo_pkg::*;
#(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int BLOCK    = 6,
    parameter int MAX_DISP = 64,
    parameter int PIX_W    = 8,
    parameter int DISP_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = $clog2(IMG_W*IMG_H),
    parameter int COST_W   = cost_width(BLOCK, PIX_W)
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              metric_sel,
    input  logic [COST_W-1:0] cost_thresh,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] left_addr,
    output logic [ADDR_W-1:0] right_addr,
    input  logic [PIX_W-1:0]  left_pix,
    input  logic [PIX_W-1:0]  right_pix,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DISP_W-1:0] res_din
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int IW = $clog2(BLOCK + 1);

    disp_state_e         state_q, state_d;
    metric_e             metric_q;
    logic [COST_W-1:0]   thresh_q;
    logic                busy_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [DISP_W-1:0]   d_q;
    logic [IW-1:0]       i_q, j_q;
    logic [COST_W-1:0]   best_cost_q;
    logic [DISP_W-1:0]   best_d_q;
    logic [RD_LAT-1:0]   vld_q, first_q;
    logic [COST_W-1:0]   cost;
    logic                acc_busy;
    logic                issue, last_ij, d_last, last_x, last_y, drain_done;

    assign issue      = (state_q == ST_ISSUE);
    assign last_ij    = (i_q == IW'(BLOCK-1)) && (j_q == IW'(BLOCK-1));
    assign last_x     = (x_q == XW'(IMG_W-BLOCK));
    assign last_y     = (y_q == YW'(IMG_H-BLOCK));
    assign drain_done = (vld_q == '0) && !acc_busy;

    // Search stops at MAX_DISP-1 or at x, whichever is smaller, so right reads stay in-image.
    always_comb begin
        if (32'(x_q) >= 32'(MAX_DISP-1)) begin
            d_last = (d_q == DISP_W'(MAX_DISP-1));
        end else begin
            d_last = (d_q == DISP_W'(x_q));
        end
    end

    // Raster addresses for the current window pixel and candidate shift.
    always_comb begin
        logic [31:0] row_w;
        row_w      = (32'(y_q) + 32'(j_q)) * 32'(IMG_W);
        left_addr  = ADDR_W'(row_w + 32'(x_q) + 32'(i_q));
        right_addr = ADDR_W'(row_w + 32'(x_q) - 32'(d_q) + 32'(i_q));
    end

    // Tag each returning BRAM sample; the first tag of a candidate clears the sum.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_q   <= '0;
            first_q <= '0;
        end else begin
            vld_q[0]   <= issue;
            first_q[0] <= issue && (i_q == '0) && (j_q == '0);
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]   <= vld_q[k-1];
                first_q[k] <= first_q[k-1];
            end
        end
    end

    block_cost_accum #(
        .PIX_W  (PIX_W),
        .COST_W (COST_W)
    ) u_accum (
        .clk_i    (clk_100mhz),
        .rst_ni   (sys_rst_n),
        .valid_i  (vld_q[RD_LAT-1]),
        .clear_i  (first_q[RD_LAT-1]),
        .metric_i (metric_q),
        .l_pix_i  (left_pix),
        .r_pix_i  (right_pix),
        .cost_o   (cost),
        .busy_o   (acc_busy)
    );

    // State register.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ISSUE;
            ST_ISSUE:   if (last_ij) state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_done) state_d = ST_COMPARE;
            ST_COMPARE: state_d = d_last ? ST_WRITE : ST_ISSUE;
            ST_WRITE:   state_d = (last_x && last_y) ? ST_FIN : ST_ISSUE;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Frame counters, sampled configuration and running best per position.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            metric_q    <= METRIC_SAD;
            thresh_q    <= '0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            d_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            best_cost_q <= '1;
            best_d_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    metric_q    <= metric_e'(metric_sel);
                    thresh_q    <= cost_thresh;
                    busy_q      <= 1'b1;
                    x_q         <= '0;
                    y_q         <= '0;
                    d_q         <= '0;
                    i_q         <= '0;
                    j_q         <= '0;
                    best_cost_q <= '1;
                    best_d_q    <= '0;
                end
                ST_ISSUE: begin
                    if (i_q == IW'(BLOCK-1)) begin
                        i_q <= '0;
                        j_q <= last_ij ? '0 : j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (cost < best_cost_q) begin
                        best_cost_q <= cost;
                        best_d_q    <= d_q;
                    end
                    if (!d_last) d_q <= d_q + 1'b1;
                end
                ST_WRITE: begin
                    d_q         <= '0;
                    best_cost_q <= '1;
                    best_d_q    <= '0;
                    if (!(last_x && last_y)) begin
                        if (last_x) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                ST_FIN: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = (state_q == ST_FIN);
    assign res_we   = (state_q == ST_WRITE);
    assign res_addr = res_we ? ADDR_W'(32'(y_q) * 32'(IMG_W) + 32'(x_q)) : '0;
    assign res_din  = !res_we ? '0 : ((best_cost_q <= thresh_q) ? best_d_q : '1);

endmodule

// File: tb/tb_stereo_disparity_engine.sv
// Directed frame-level bench for the disparity engine on a 16x8 image.
module tb_stereo_disparity_engine;
    import stereo_pkg::*;

    localparam int IMG_W    = 16;
    localparam int IMG_H    = 8;
    localparam int BLOCK    = 2;
    localparam int MAX_DISP = 4;
    localparam int PIX_W    = 8;
    localparam int DISP_W   = 8;
    localparam int RD_LAT   = 2;
    localparam int ADDR_W   = $clog2(IMG_W*IMG_H);
    localparam int COST_W   = cost_width(BLOCK, PIX_W);
    localparam int NX       = IMG_W - BLOCK + 1;
    localparam int NY       = IMG_H - BLOCK + 1;
    localparam int NPOS     = NX * NY;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int BUDGET   = 20000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              metric_sel = 1'b0;
    logic [COST_W-1:0] cost_thresh = '0;
    logic              busy, done, res_we;
    logic [ADDR_W-1:0] left_addr, right_addr, res_addr;
    logic [PIX_W-1:0]  left_pix, right_pix;
    logic [DISP_W-1:0] res_din;

    stereo_disparity_engine #(
        .IMG_W (IMG_W), .IMG_H (IMG_H), .BLOCK (BLOCK), .MAX_DISP (MAX_DISP),
        .PIX_W (PIX_W), .DISP_W (DISP_W), .RD_LAT (RD_LAT)
    ) dut (
        .clk_100mhz  (clk),
        .sys_rst_n   (rst_n),
        .start       (start),
        .metric_sel  (metric_sel),
        .cost_thresh (cost_thresh),
        .busy        (busy),
        .done        (done),
        .left_addr   (left_addr),
        .right_addr  (right_addr),
        .left_pix    (left_pix),
        .right_pix   (right_pix),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .res_din     (res_din)
    );

    always #5 clk = ~clk;

    // Frame BRAM models with two cycles of read latency.
    logic [PIX_W-1:0] lmem [NPIX];
    logic [PIX_W-1:0] rmem [NPIX];
    logic [PIX_W-1:0] l_d1, r_d1;
    always @(posedge clk) begin
        l_d1      <= lmem[left_addr];
        r_d1      <= rmem[right_addr];
        left_pix  <= l_d1;
        right_pix <= r_d1;
    end

    typedef enum int {IMG_SAME_RAND, IMG_SHIFT2, IMG_UNIFORM, IMG_RAND} img_e;
    typedef enum int {EXP_CONST, EXP_SHIFT, EXP_MODEL} exp_e;
    typedef struct {
        img_e              img;
        logic              metric;
        logic [COST_W-1:0] thresh;
        exp_e              kind;
        int                const_val;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int got [NPIX];

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic load_image(input img_e img);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                case (img)
                    IMG_SAME_RAND: begin
                        lmem[y*IMG_W+x] = PIX_W'($urandom_range(0, 255));
                        rmem[y*IMG_W+x] = lmem[y*IMG_W+x];
                    end
                    IMG_SHIFT2: begin
                        lmem[y*IMG_W+x] = PIX_W'(x*12 + y*3);
                        rmem[y*IMG_W+x] = PIX_W'((x+2)*12 + y*3);
                    end
                    IMG_UNIFORM: begin
                        lmem[y*IMG_W+x] = 8'd10;
                        rmem[y*IMG_W+x] = 8'd13;
                    end
                    default: begin
                        lmem[y*IMG_W+x] = PIX_W'($urandom_range(0, 255));
                        rmem[y*IMG_W+x] = PIX_W'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    // Straightforward block-matching reference for one window position.
    function automatic int ref_disp(input int x, input int y, input logic m, input longint thr);
        longint best = 64'h7FFF_FFFF_FFFF_FFFF;
        int     bd   = 0;
        int     dmax = (x < MAX_DISP-1) ? x : MAX_DISP-1;
        for (int d = 0; d <= dmax; d++) begin
            longint c = 0;
            for (int j = 0; j < BLOCK; j++) begin
                for (int i = 0; i < BLOCK; i++) begin
                    int df = int'(lmem[(y+j)*IMG_W+x+i]) - int'(rmem[(y+j)*IMG_W+x-d+i]);
                    c += m ? longint'(df*df) : longint'((df < 0) ? -df : df);
                end
            end
            if (c < best) begin
                best = c;
                bd   = d;
            end
        end
        return (best <= thr) ? bd : 255;
    endfunction

    // Runs one frame from a negedge; captures writes and done pulses, optional start spam.
    task automatic run_frame(input logic m, input logic [COST_W-1:0] t, input bit spam,
                             output int wr_cnt, output int done_cnt);
        bit finished = 0;
        int tail = 0;
        for (int k = 0; k < NPIX; k++) got[k] = -1;
        wr_cnt = 0;
        done_cnt = 0;
        metric_sel = m;
        cost_thresh = t;
        start = 1'b1;
        for (int c = 0; c < BUDGET && tail < 60; c++) begin
            @(negedge clk);
            start = spam && !finished && (c % 50 == 49);
            if (c == 0) check("busy_after_start", busy, 1);
            if (res_we) begin
                if (wr_cnt < NPOS)
                    check("write_order", res_addr, (wr_cnt / NX) * IMG_W + wr_cnt % NX);
                got[res_addr] = int'(res_din);
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                finished = 1;
            end
            if (finished) tail++;
        end
        start = 1'b0;
        if (!finished) check("frame_timeout", 0, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_results(input vec_t v, input int vi);
        for (int p = 0; p < NPOS; p++) begin
            int x = p % NX;
            int y = p / NX;
            int req;
            case (v.kind)
                EXP_CONST: req = v.const_val;
                EXP_SHIFT: req = (x < 2) ? x : 2;
                default:   req = ref_disp(x, y, v.metric, longint'(v.thresh));
            endcase
            check($sformatf("vec%0d res_din x=%0d y=%0d", vi, x, y), got[y*IMG_W+x], req);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int wr, dn, guard;

        // Reset state: every output low.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_we", res_we, 0);
        check("rst_res_addr", res_addr, 0);
        check("rst_res_din", res_din, 0);
        check("rst_left_addr", left_addr, 0);
        check("rst_right_addr", right_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{IMG_SAME_RAND, 1'b0, '1,          EXP_CONST, 0};
        vecs[1] = '{IMG_SHIFT2,    1'b0, '1,          EXP_SHIFT, 0};
        vecs[2] = '{IMG_UNIFORM,   1'b0, COST_W'(20), EXP_CONST, 0};
        vecs[3] = '{IMG_UNIFORM,   1'b1, COST_W'(20), EXP_CONST, 255};
        vecs[4] = '{IMG_RAND,      1'b0, '0,          EXP_MODEL, 0};
        vecs[5] = '{IMG_RAND,      1'b1, '1,          EXP_MODEL, 0};

        for (int vi = 0; vi < 6; vi++) begin
            load_image(vecs[vi].img);
            run_frame(vecs[vi].metric, vecs[vi].thresh, 1'b0, wr, dn);
            check($sformatf("vec%0d write_count", vi), wr, NPOS);
            check($sformatf("vec%0d done_count", vi), dn, 1);
            check_results(vecs[vi], vi);
            $display("vector %0d: img=%0d metric=%0d thresh=%0d writes=%0d dones=%0d",
                     vi, vecs[vi].img, vecs[vi].metric, vecs[vi].thresh, wr, dn);
        end

        // Asynchronous reset while addresses are being issued, then a clean frame.
        load_image(IMG_SAME_RAND);
        metric_sel = 1'b0;
        cost_thresh = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (guard < 300 && !(guard > 100 && dut.state_q == ST_ISSUE)) begin
            @(negedge clk);
            guard++;
        end
        check("reset_reached_issue", (dut.state_q == ST_ISSUE), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_we", res_we, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, '1, 1'b0, wr, dn);
        check("post_reset write_count", wr, NPOS);
        check("post_reset done_count", dn, 1);
        check_results('{IMG_SAME_RAND, 1'b0, '1, EXP_CONST, 0}, 10);
        $display("reset frame: writes=%0d dones=%0d", wr, dn);

        // start pulses during a running frame must be dropped.
        load_image(IMG_SHIFT2);
        run_frame(1'b0, '1, 1'b1, wr, dn);
        check("spam write_count", wr, NPOS);
        check("spam done_count", dn, 1);
        check_results('{IMG_SHIFT2, 1'b0, '1, EXP_SHIFT, 0}, 11);
        $display("start-spam frame: writes=%0d dones=%0d", wr, dn);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
